heart_motion_ctrl: RTL

- Per-frame sequencer for the player heart sprite inside the battle box.
- Samples the direction buttons once per frame and steps the sprite's top-left position, clamped to the box.
- Runs a hit/invulnerability state machine that blinks the sprite.
- Its o_x/o_y/o_visible drive the sprite renderer's position registers and on-gate.

---
 rtl/heart_motion_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/heart_motion_ctrl.sv
// Heart sprite sequencer: samples the direction buttons once per frame, steps and clamps
// the sprite position inside the battle box, and runs the hit/invulnerability blink FSM.
module heart_motion_ctrl #(
   parameter int unsigned BOX_LEFT      = 220,
   parameter int unsigned BOX_RIGHT     = 420,
   parameter int unsigned BOX_TOP       = 240,
   parameter int unsigned BOX_BOTTOM    = 400,
   parameter int unsigned SPR_W         = 16,
   parameter int unsigned SPR_H         = 16,
   parameter int unsigned STEP          = 3,
   parameter int unsigned START_X       = 312,
   parameter int unsigned START_Y       = 312,
   parameter int unsigned INVULN_FRAMES = 60,
   parameter int unsigned BLINK_PERIOD  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_frame_tick,
   input  logic       i_enable,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   input  logic       i_hit,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_visible,
   output logic       o_invuln,
   output logic       o_hit_ack,
   output logic [1:0] o_state
);

   localparam int unsigned POS_W   = 10;
   localparam int unsigned SUM_W   = 11;
   localparam int unsigned INV_W   = 8;
   localparam int unsigned BLINK_W = 4;
   localparam int unsigned X_MAX   = BOX_RIGHT - SPR_W;
   localparam int unsigned Y_MAX   = BOX_BOTTOM - SPR_H;

   localparam logic signed [SUM_W-1:0] X_MIN_S = SUM_W'(BOX_LEFT);
   localparam logic signed [SUM_W-1:0] X_MAX_S = SUM_W'(X_MAX);
   localparam logic signed [SUM_W-1:0] Y_MIN_S = SUM_W'(BOX_TOP);
   localparam logic signed [SUM_W-1:0] Y_MAX_S = SUM_W'(Y_MAX);
   localparam logic signed [SUM_W-1:0] STEP_S  = SUM_W'(STEP);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MOVE = 2'b01,
      ST_HIT  = 2'b10
   } state_t;

   state_t                    state;
   logic [INV_W-1:0]          invuln_cnt;
   logic [BLINK_W-1:0]        blink_cnt;
   logic signed [SUM_W-1:0]   dx_c;
   logic signed [SUM_W-1:0]   dy_c;
   logic signed [SUM_W-1:0]   sum_x_c;
   logic signed [SUM_W-1:0]   sum_y_c;
   logic [POS_W-1:0]          next_x_c;
   logic [POS_W-1:0]          next_y_c;

   assign o_state = state;

   // Per-frame step with opposite buttons cancelling, clamped to the box on both axes
   always_comb begin
      dx_c = '0;
      dy_c = '0;
      if (i_right && !i_left)      dx_c = STEP_S;
      else if (i_left && !i_right) dx_c = -STEP_S;
      if (i_down && !i_up)         dy_c = STEP_S;
      else if (i_up && !i_down)    dy_c = -STEP_S;

      sum_x_c = $signed({1'b0, o_x}) + dx_c;
      sum_y_c = $signed({1'b0, o_y}) + dy_c;

      if (sum_x_c < X_MIN_S)      next_x_c = POS_W'(BOX_LEFT);
      else if (sum_x_c > X_MAX_S) next_x_c = POS_W'(X_MAX);
      else                        next_x_c = POS_W'(sum_x_c);

      if (sum_y_c < Y_MIN_S)      next_y_c = POS_W'(BOX_TOP);
      else if (sum_y_c > Y_MAX_S) next_y_c = POS_W'(Y_MAX);
      else                        next_y_c = POS_W'(sum_y_c);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         o_x        <= POS_W'(START_X);
         o_y        <= POS_W'(START_Y);
         o_visible  <= 1'b1;
         o_invuln   <= 1'b0;
         o_hit_ack  <= 1'b0;
         invuln_cnt <= '0;
         blink_cnt  <= '0;
      end else begin
         o_hit_ack <= 1'b0;
         // Disable wins over ticks and hits, and swallows any ack this cycle
         if (!i_enable) begin
            state      <= ST_IDLE;
            o_x        <= POS_W'(START_X);
            o_y        <= POS_W'(START_Y);
            o_visible  <= 1'b1;
            o_invuln   <= 1'b0;
            invuln_cnt <= '0;
            blink_cnt  <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_MOVE;
               end
               ST_MOVE: begin
                  if (i_frame_tick) begin
                     o_x <= next_x_c;
                     o_y <= next_y_c;
                  end
                  // A coincident tick moves the sprite but does not eat an invuln frame
                  if (i_hit) begin
                     state      <= ST_HIT;
                     o_invuln   <= 1'b1;
                     o_visible  <= 1'b0;
                     o_hit_ack  <= 1'b1;
                     invuln_cnt <= INV_W'(INVULN_FRAMES);
                     blink_cnt  <= '0;
                  end
               end
               ST_HIT: begin
                  if (i_frame_tick) begin
                     o_x <= next_x_c;
                     o_y <= next_y_c;
                     if (invuln_cnt == INV_W'(1)) begin
                        state      <= ST_MOVE;
                        o_invuln   <= 1'b0;
                        o_visible  <= 1'b1;
                        invuln_cnt <= '0;
                        blink_cnt  <= '0;
                     end else begin
                        invuln_cnt <= invuln_cnt - INV_W'(1);
                        if (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
                           blink_cnt <= '0;
                           o_visible <= ~o_visible;
                        end else begin
                           blink_cnt <= blink_cnt + BLINK_W'(1);
                        end
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
